frame_stream_check: RTL and testbench
=====================================

# frame_stream_check

Parametrised receive-side checker for the GMII video test stream. Each valid word carries a line number field and a pixel byte. The block locks onto frame boundaries and tracks the expected line number and pixel position. It compares every word against a selectable test pattern and reports pixel errors, resync events, a frame counter and lock status to the board LEDs and debug logic in the 125 MHz receive domain.

## Interface
Parameters:
- H_ACTIVE, 1280, pixels per line
- V_ACTIVE, 720, lines per frame
- Y_W, 11, line-number field width
- Y_LSB, 16, LSB position of line field in din
- DIN_W, 29, input word width
- BARS, 2, vertical bars in bar patterns (power of two, 2..16)
- ERR_W, 16, error counter width
- FRM_W, 8, frame counter width

Ports:
- clk125m  in  1  receive clock
- reset  in  1  asynchronous, active-high reset
- din_valid  in  1  din qualifier (FIFO write enable)
- din  in  DIN_W  word: line = din[Y_LSB+Y_W-1:Y_LSB], pixel = din[7:0]
- mode  in  2  pattern select: 0 bar bit, 1 bar byte, 2 ramp, 3 line-only
- clear  in  1  synchronous clear of all counters
- locked  out  1  high while in LOCK
- err_pulse  out  1  one-cycle pulse per counted pixel error
- err_cnt  out  ERR_W  saturating pixel-error count
- resync_cnt  out  ERR_W  saturating count of LOCK→HUNT drops
- frame_cnt  out  FRM_W  wrapping count of complete checked frames
- frame_toggle  out  1  frame_cnt[0]

## Operation
- State machine, transitions only on din_valid = 1:
  - IDLE → HUNT on the first valid word.
  - HUNT:
    - x counter increments while the line is V_ACTIVE-1.
    - x counter clears to 0 on any other line.
    - When the line is V_ACTIVE-1 and x = H_ACTIVE-1: go to LOCK with expected line ey = 0 and x = 0.
  - LOCK:
    - Compare line to ey.
    - On mismatch: go to HUNT, clear x, increment resync_cnt, suppress the pixel compare for that word.
    - On match: do the pixel compare, then advance.
- Advance:
  - x = H_ACTIVE-1 wraps x to 0.
  - ey then wraps from V_ACTIVE-1 to 0, and frame_cnt increments.
  - Otherwise x increments.
- Expected pixel, with bar = x·BARS/H_ACTIVE (integer):
  - mode 0: compare bit 7 only; expected = bar[log2(BARS)-1].
  - mode 1: full byte; expected = bar·(256/BARS).
  - mode 2: full byte; expected = x[7:0].
  - mode 3: no pixel compare.
- A pixel mismatch increments err_cnt (saturating at all-ones) and pulses err_pulse.
- Counter rules:
  - clear zeroes err_cnt, resync_cnt and frame_cnt.
  - clear has priority over a simultaneous increment.
  - clear does not affect the FSM.
- A mode change takes effect on the next valid word; there is no resync.

## Timing
- All outputs are registered and update one cycle after the valid word that causes them.
- Reset values: locked 0, err_pulse 0, all counters 0, FSM IDLE, x 0, ey 0.
- Reset asserted mid-frame returns the block to IDLE immediately and asynchronously. After release, at least one full last line must be seen before locked rises.
- din_valid = 0: no state, counter or pulse change.
- The minimum lock latency from the start of the last line is H_ACTIVE valid words. locked rises in the cycle after the H_ACTIVE-th word.

## Configuration
- FRMCHK_FIRST_ERR_EN
  - Defined: adds outputs first_err_y (Y_W), first_err_x (11) and first_err_data (8), plus flag first_err_vld.
    - These capture ey, x and din[7:0] of the first pixel error after reset or clear.
    - They hold until the next clear; clear zeroes all four.
  - Undefined: the ports and registers are absent, and other behaviour is identical.

## Structure
- Package frmchk_pkg holds:
  - state encodings: IDLE 2'b00, HUNT 2'b10, LOCK 2'b11
  - mode constants: MODE_BIT, MODE_BYTE, MODE_RAMP, MODE_LINE
  - the saturating-increment function
- Sub-module frmchk_pattern_gen: combinational expected byte and compare mask from x and mode, parametrised by H_ACTIVE and BARS.

## Test plan
All scenarios use H_ACTIVE=16, V_ACTIVE=4, BARS=2.
- **Clean lock, mode 0:** 3 clean frames (bit 7 = 0 for x<8, else 1) → locked rises after the 16th word of line 3; frame_cnt = 2 after frames 2–3 complete; err_cnt = 0.
- **Pixel error:** with lock held, flip bit 7 at line 1, x 5 → err_cnt = 1, single err_pulse, locked stays 1. With FRMCHK_FIRST_ERR_EN defined, first_err_y = 1 and first_err_x = 5.
- **Dropped word:** delete one word in line 2 → resync_cnt = 1, locked falls, no pixel error counted for that word, relock at the end of the next line 3.
- **Ramp and saturation:** mode 2 ramp with ERR_W = 4 and 20 corrupted pixels → err_cnt saturates at 15.
- **Clear vs increment:** clear asserted in the same cycle as an error word → err_cnt = 0 next cycle; FSM stays LOCK.
- **Reset mid-frame:** assert reset mid-frame → all outputs 0 asynchronously; after release, no lock until a full line 3 is seen.

Source files
------------

// File: rtl/frmchk_pkg.sv
// Shared state encodings, pattern modes and counter helpers for the frame stream checker.
package frmchk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HUNT = 2'b10,
    LOCK = 2'b11
  } state_t;

  localparam logic [1:0] MODE_BIT  = 2'd0;
  localparam logic [1:0] MODE_BYTE = 2'd1;
  localparam logic [1:0] MODE_RAMP = 2'd2;
  localparam logic [1:0] MODE_LINE = 2'd3;

  // Increment that sticks at the all-ones value of a width-bit counter (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/frmchk_pattern_gen.sv
// Expected pixel byte and compare mask for the selected test pattern at pixel position x.
module frmchk_pattern_gen
  import frmchk_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int BARS     = 2,
  parameter int X_W      = $clog2(H_ACTIVE)
) (
  input  logic [X_W-1:0] x,
  input  logic [1:0]     mode,
  output logic [7:0]     expected,
  output logic [7:0]     mask
);

  localparam int BAR_W = (BARS > 1) ? $clog2(BARS) : 1;

  logic [BAR_W-1:0] bar;

  assign bar = BAR_W'((32'(x) * 32'(BARS)) / 32'(H_ACTIVE));

  always_comb begin
    expected = '0;
    mask     = '0;
    case (mode)
      MODE_BIT: begin
        expected = {bar[BAR_W-1], 7'b0};
        mask     = 8'h80;
      end
      MODE_BYTE: begin
        expected = 8'(32'(bar) * (32'd256 / 32'(BARS)));
        mask     = 8'hFF;
      end
      MODE_RAMP: begin
        expected = 8'(x);
        mask     = 8'hFF;
      end
      default: begin
        // line-only mode: nothing to compare
        expected = '0;
        mask     = '0;
      end
    endcase
  end

endmodule

// File: rtl/frame_stream_check.sv
// Receive-side frame lock, pattern compare and statistics for the GMII video test stream.
// Optional first-error capture ports are built when FRMCHK_FIRST_ERR_EN is defined.
module frame_stream_check
  import frmchk_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int Y_W      = 11,
  parameter int Y_LSB    = 16,
  parameter int DIN_W    = 29,
  parameter int BARS     = 2,
  parameter int ERR_W    = 16,
  parameter int FRM_W    = 8
) (
  input  logic             clk125m,
  input  logic             reset,
  input  logic             din_valid,
  input  logic [DIN_W-1:0] din,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] resync_cnt,
  output logic [FRM_W-1:0] frame_cnt,
  output logic             frame_toggle
`ifdef FRMCHK_FIRST_ERR_EN
  ,
  output logic [Y_W-1:0]   first_err_y,
  output logic [10:0]      first_err_x,
  output logic [7:0]       first_err_data,
  output logic             first_err_vld
`endif
);

  localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

  state_t           state_reg, state_next;
  logic [X_W-1:0]   x_reg, x_next;
  logic [Y_W-1:0]   ey_reg, ey_next;
  logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;
  logic [ERR_W-1:0] resync_cnt_reg, resync_cnt_next;
  logic [FRM_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic             err_pulse_reg, err_pulse_next;
  logic             locked_reg, locked_next;

  logic [Y_W-1:0]   line;
  logic [7:0]       pixel;
  logic [7:0]       exp_pixel;
  logic [7:0]       exp_mask;
  logic             pix_err;
  logic             err_hit;
  logic             resync_hit;
  logic             frame_hit;
  logic             unused_din;

  assign line       = din[Y_LSB+Y_W-1:Y_LSB];
  assign pixel      = din[7:0];
  assign unused_din = ^din;

  frmchk_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .BARS     (BARS),
    .X_W      (X_W)
  ) u_pattern (
    .x        (x_reg),
    .mode     (mode),
    .expected (exp_pixel),
    .mask     (exp_mask)
  );

  assign pix_err = |((pixel ^ exp_pixel) & exp_mask);

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    ey_next    = ey_reg;
    err_hit    = 1'b0;
    resync_hit = 1'b0;
    frame_hit  = 1'b0;
    if (din_valid) begin
      case (state_reg)
        IDLE: state_next = HUNT;
        HUNT: begin
          // only an unbroken run of H_ACTIVE last-line words establishes lock
          if (line == Y_LAST) begin
            if (x_reg == X_LAST) begin
              state_next = LOCK;
              x_next     = '0;
              ey_next    = '0;
            end else begin
              x_next = x_reg + 1'b1;
            end
          end else begin
            x_next = '0;
          end
        end
        LOCK: begin
          if (line != ey_reg) begin
            state_next = HUNT;
            x_next     = '0;
            resync_hit = 1'b1;
          end else begin
            err_hit = pix_err;
            if (x_reg == X_LAST) begin
              x_next = '0;
              if (ey_reg == Y_LAST) begin
                ey_next   = '0;
                frame_hit = 1'b1;
              end else begin
                ey_next = ey_reg + 1'b1;
              end
            end else begin
              x_next = x_reg + 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    err_cnt_next    = err_cnt_reg;
    resync_cnt_next = resync_cnt_reg;
    frame_cnt_next  = frame_cnt_reg;
    err_pulse_next  = err_hit & ~clear;
    locked_next     = (state_next == LOCK);
    if (clear) begin
      err_cnt_next    = '0;
      resync_cnt_next = '0;
      frame_cnt_next  = '0;
    end else begin
      if (err_hit)
        err_cnt_next = ERR_W'(sat_inc(32'(err_cnt_reg), ERR_W));
      if (resync_hit)
        resync_cnt_next = ERR_W'(sat_inc(32'(resync_cnt_reg), ERR_W));
      if (frame_hit)
        frame_cnt_next = frame_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk125m or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      x_reg          <= '0;
      ey_reg         <= '0;
      err_cnt_reg    <= '0;
      resync_cnt_reg <= '0;
      frame_cnt_reg  <= '0;
      err_pulse_reg  <= 1'b0;
      locked_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      x_reg          <= x_next;
      ey_reg         <= ey_next;
      err_cnt_reg    <= err_cnt_next;
      resync_cnt_reg <= resync_cnt_next;
      frame_cnt_reg  <= frame_cnt_next;
      err_pulse_reg  <= err_pulse_next;
      locked_reg     <= locked_next;
    end
  end

  assign locked       = locked_reg;
  assign err_pulse    = err_pulse_reg;
  assign err_cnt      = err_cnt_reg;
  assign resync_cnt   = resync_cnt_reg;
  assign frame_cnt    = frame_cnt_reg;
  assign frame_toggle = frame_cnt_reg[0];

`ifdef FRMCHK_FIRST_ERR_EN
  logic [Y_W-1:0] fe_y_reg, fe_y_next;
  logic [10:0]    fe_x_reg, fe_x_next;
  logic [7:0]     fe_data_reg, fe_data_next;
  logic           fe_vld_reg, fe_vld_next;

  always_comb begin
    fe_y_next    = fe_y_reg;
    fe_x_next    = fe_x_reg;
    fe_data_next = fe_data_reg;
    fe_vld_next  = fe_vld_reg;
    if (clear) begin
      fe_y_next    = '0;
      fe_x_next    = '0;
      fe_data_next = '0;
      fe_vld_next  = 1'b0;
    end else if (err_hit && !fe_vld_reg) begin
      fe_y_next    = ey_reg;
      fe_x_next    = 11'(x_reg);
      fe_data_next = pixel;
      fe_vld_next  = 1'b1;
    end
  end

  always_ff @(posedge clk125m or posedge reset) begin
    if (reset) begin
      fe_y_reg    <= '0;
      fe_x_reg    <= '0;
      fe_data_reg <= '0;
      fe_vld_reg  <= 1'b0;
    end else begin
      fe_y_reg    <= fe_y_next;
      fe_x_reg    <= fe_x_next;
      fe_data_reg <= fe_data_next;
      fe_vld_reg  <= fe_vld_next;
    end
  end

  assign first_err_y    = fe_y_reg;
  assign first_err_x    = fe_x_reg;
  assign first_err_data = fe_data_reg;
  assign first_err_vld  = fe_vld_reg;
`endif

endmodule

// File: tb/tb_frame_stream_check.sv
// Scoreboard bench for frame_stream_check: a position-based reference model feeds an expectation queue.
module tb_frame_stream_check;

  localparam int H       = 16;
  localparam int V       = 4;
  localparam int BARS_P  = 2;
  localparam int ERR_W_P = 4;
  localparam int FRM_W_P = 8;
  localparam int Y_W_P   = 11;
  localparam int Y_LSB_P = 16;
  localparam int DIN_W_P = 29;
  localparam int ERR_MAX = (1 << ERR_W_P) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               din_valid;
  logic [DIN_W_P-1:0] din;
  logic [1:0]         mode;
  logic               clear;
  logic               locked;
  logic               err_pulse;
  logic [ERR_W_P-1:0] err_cnt;
  logic [ERR_W_P-1:0] resync_cnt;
  logic [FRM_W_P-1:0] frame_cnt;
  logic               frame_toggle;
`ifdef FRMCHK_FIRST_ERR_EN
  logic [Y_W_P-1:0]   first_err_y;
  logic [10:0]        first_err_x;
  logic [7:0]         first_err_data;
  logic               first_err_vld;
`endif

  frame_stream_check #(
    .H_ACTIVE (H), .V_ACTIVE (V), .Y_W (Y_W_P), .Y_LSB (Y_LSB_P),
    .DIN_W (DIN_W_P), .BARS (BARS_P), .ERR_W (ERR_W_P), .FRM_W (FRM_W_P)
  ) dut (
    .clk125m      (clk),
    .reset        (reset),
    .din_valid    (din_valid),
    .din          (din),
    .mode         (mode),
    .clear        (clear),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_cnt      (err_cnt),
    .resync_cnt   (resync_cnt),
    .frame_cnt    (frame_cnt),
    .frame_toggle (frame_toggle)
`ifdef FRMCHK_FIRST_ERR_EN
    ,
    .first_err_y    (first_err_y),
    .first_err_x    (first_err_x),
    .first_err_data (first_err_data),
    .first_err_vld  (first_err_vld)
`endif
  );

  always #4 clk = ~clk;

  typedef struct {
    int lck;
    int pulse;
    int errc;
    int resc;
    int frm;
    int fev;
    int fey;
    int fex;
    int fed;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;
  int   pulse_seen = 0;
  int   cur_mode = 0;

  // reference model: stream position kept as a linear index into the frame
  int m_started, m_locked, m_run, m_pos;
  int m_errc, m_resc, m_frm;
  int m_fev, m_fey, m_fex, m_fed;

  function automatic void chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endfunction

  function automatic int pix_bad(input int md, input int xx, input int pix);
    int bar;
    bar = xx * BARS_P / H;
    case (md)
      0: return (((pix >> 7) & 1) != ((bar * 2 >= BARS_P) ? 1 : 0)) ? 1 : 0;
      1: return (pix != bar * 256 / BARS_P) ? 1 : 0;
      2: return (pix != xx % 256) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int good_pix(input int md, input int xx);
    int bar;
    bar = xx * BARS_P / H;
    case (md)
      0: return ((bar * 2 >= BARS_P) ? 128 : 0) + int'($urandom_range(0, 127));
      1: return bar * 256 / BARS_P;
      2: return xx % 256;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic model_reset();
    m_started = 0; m_locked = 0; m_run = 0; m_pos = 0;
    m_errc = 0; m_resc = 0; m_frm = 0;
    m_fev = 0; m_fey = 0; m_fex = 0; m_fed = 0;
  endtask

  task automatic model_step(input int v, input int line, input int pix, input int clr, input int md);
    exp_t e;
    int err, res, frm;
    err = 0; res = 0; frm = 0;
    if (v != 0) begin
      if (m_started == 0) begin
        m_started = 1;
      end else if (m_locked == 0) begin
        if (line == V - 1) begin
          m_run++;
          if (m_run == H) begin
            m_locked = 1; m_pos = 0; m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end else if (line != m_pos / H) begin
        m_locked = 0; m_run = 0; res = 1;
      end else begin
        err = pix_bad(md, m_pos % H, pix);
        if (err != 0 && clr == 0 && m_fev == 0) begin
          m_fev = 1; m_fey = m_pos / H; m_fex = m_pos % H; m_fed = pix;
        end
        m_pos++;
        if (m_pos == H * V) begin
          m_pos = 0; frm = 1;
        end
      end
    end
    if (clr != 0) begin
      m_errc = 0; m_resc = 0; m_frm = 0;
      m_fev = 0; m_fey = 0; m_fex = 0; m_fed = 0;
    end else begin
      if (err != 0) m_errc = (m_errc < ERR_MAX) ? m_errc + 1 : ERR_MAX;
      if (res != 0) m_resc = (m_resc < ERR_MAX) ? m_resc + 1 : ERR_MAX;
      if (frm != 0) m_frm = (m_frm + 1) % (1 << FRM_W_P);
    end
    e.lck = m_locked; e.pulse = (err != 0 && clr == 0) ? 1 : 0;
    e.errc = m_errc; e.resc = m_resc; e.frm = m_frm;
    e.fev = m_fev; e.fey = m_fey; e.fex = m_fex; e.fed = m_fed;
    q.push_back(e);
  endtask

  task automatic cycle(input int v, input int line, input int pix, input int clr);
    logic [DIN_W_P-1:0] w;
    @(negedge clk);
    w = DIN_W_P'($urandom);
    w[Y_LSB_P +: Y_W_P] = Y_W_P'(line);
    w[7:0] = 8'(pix);
    din       = w;
    din_valid = (v != 0);
    clear     = (clr != 0);
    mode      = 2'(cur_mode);
    @(posedge clk);
    model_step(v, line, pix, clr, cur_mode);
  endtask

  task automatic send(input int line, input int pix, input int clr);
    if ($urandom_range(0, 3) == 0)
      cycle(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 0);
    cycle(1, line, pix, clr);
  endtask

  task automatic send_frame(input int md, input int drop_y, input int drop_x,
                            input int flip_y, input int flip_x, input int flip_mask,
                            input int clr_y, input int clr_x);
    int pix;
    cur_mode = md;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        if (y == drop_y && x == drop_x) continue;
        pix = good_pix(md, x);
        if (y == flip_y && x == flip_x) pix = pix ^ flip_mask;
        send(y, pix, (y == clr_y && x == clr_x) ? 1 : 0);
      end
    end
  endtask

  task automatic drain();
    cycle(0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      txn++;
      if (err_pulse) pulse_seen++;
      $display("txn %0d: locked=%0d pulse=%0d err=%0d resync=%0d frames=%0d",
               txn, locked, err_pulse, err_cnt, resync_cnt, frame_cnt);
      chk("locked", int'(locked), mon_e.lck);
      chk("err_pulse", int'(err_pulse), mon_e.pulse);
      chk("err_cnt", int'(err_cnt), mon_e.errc);
      chk("resync_cnt", int'(resync_cnt), mon_e.resc);
      chk("frame_cnt", int'(frame_cnt), mon_e.frm);
      chk("frame_toggle", int'(frame_toggle), mon_e.frm & 1);
`ifdef FRMCHK_FIRST_ERR_EN
      chk("first_err_vld", int'(first_err_vld), mon_e.fev);
      chk("first_err_y", int'(first_err_y), mon_e.fey);
      chk("first_err_x", int'(first_err_x), mon_e.fex);
      chk("first_err_data", int'(first_err_data), mon_e.fed);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int corrupt;
    int md, dy, dx, fy, fx, cy, cx;
    reset = 1'b1; din_valid = 1'b0; din = '0; mode = 2'd0; clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_resync_cnt", int'(resync_cnt), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    drain();

    // clean lock on bar-bit pattern
    for (int f = 0; f < 3; f++) send_frame(0, -1, -1, -1, -1, 0, -1, -1);
    drain();
    chk("clean_locked", int'(locked), 1);
    chk("clean_frame_cnt", int'(frame_cnt), 2);
    chk("clean_err_cnt", int'(err_cnt), 0);

    // single bit-7 error at line 1, x 5
    p0 = pulse_seen;
    send_frame(0, -1, -1, 1, 5, 8'h80, -1, -1);
    drain();
    chk("pixerr_err_cnt", int'(err_cnt), 1);
    chk("pixerr_pulses", pulse_seen - p0, 1);
    chk("pixerr_locked", int'(locked), 1);
`ifdef FRMCHK_FIRST_ERR_EN
    chk("pixerr_first_y", int'(first_err_y), 1);
    chk("pixerr_first_x", int'(first_err_x), 5);
`endif

    // dropped word in line 2; shift stays inside one bar so no pixel errors
    send_frame(0, 2, 10, -1, -1, 0, -1, -1);
    drain();
    chk("drop_resync_cnt", int'(resync_cnt), 1);
    chk("drop_locked", int'(locked), 0);
    chk("drop_err_cnt", int'(err_cnt), 1);
    send_frame(0, -1, -1, -1, -1, 0, -1, -1);
    drain();
    chk("relock_locked", int'(locked), 1);

    // mode changes while locked, then ramp saturation
    send_frame(1, -1, -1, -1, -1, 0, -1, -1);
    send_frame(2, -1, -1, -1, -1, 0, -1, -1);
    send_frame(3, -1, -1, -1, -1, 0, -1, -1);
    drain();
    chk("modes_err_cnt", int'(err_cnt), 1);
    chk("modes_resync_cnt", int'(resync_cnt), 1);
    cur_mode = 2;
    corrupt = 0;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        if (corrupt < 20) begin
          send(y, (x % 256) ^ int'($urandom_range(1, 255)), 0);
          corrupt++;
        end else begin
          send(y, x % 256, 0);
        end
      end
    end
    drain();
    chk("sat_err_cnt", int'(err_cnt), ERR_MAX);
    chk("sat_locked", int'(locked), 1);

    // clear coincident with an error word
    send_frame(2, -1, -1, 0, 3, 8'h55, 0, 3);
    drain();
    chk("clear_err_cnt", int'(err_cnt), 0);
    chk("clear_resync_cnt", int'(resync_cnt), 0);
    chk("clear_frame_cnt", int'(frame_cnt), 1);
    chk("clear_locked", int'(locked), 1);

    // asynchronous reset in the middle of the last line
    cur_mode = 0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < ((y == V - 1) ? 6 : H); x++)
        send(y, good_pix(0, x), 0);
    drain();
    reset = 1'b1;
    #1;
    chk("arst_locked", int'(locked), 0);
    chk("arst_err_pulse", int'(err_pulse), 0);
    chk("arst_err_cnt", int'(err_cnt), 0);
    chk("arst_resync_cnt", int'(resync_cnt), 0);
    chk("arst_frame_cnt", int'(frame_cnt), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int x = 6; x < H; x++) send(V - 1, good_pix(0, x), 0);
    drain();
    chk("arst_nolock", int'(locked), 0);
    send_frame(0, -1, -1, -1, -1, 0, -1, -1);
    drain();
    chk("arst_relock", int'(locked), 1);

    // randomized frames: modes, flips, drops and clears
    for (int r = 0; r < 6; r++) begin
      md = int'($urandom_range(0, 3));
      dy = -1; dx = -1; fy = -1; fx = -1; cy = -1; cx = -1;
      if ($urandom_range(0, 3) == 0) begin dy = int'($urandom_range(0, V - 1)); dx = int'($urandom_range(0, H - 1)); end
      if ($urandom_range(0, 1) == 0) begin fy = int'($urandom_range(0, V - 1)); fx = int'($urandom_range(0, H - 1)); end
      if ($urandom_range(0, 3) == 0) begin cy = int'($urandom_range(0, V - 1)); cx = int'($urandom_range(0, H - 1)); end
      send_frame(md, dy, dx, fy, fx, int'($urandom_range(1, 255)), cy, cx);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
